// File: rtl/narrow_check.sv
// narrow_check: narrows an N_WIDE-bit two's-complement value to N_NARROW
// signed bits, flags values that do not fit, and buffers results in a
// 2-entry FIFO with valid/ready on both sides. Overflow events accepted on
// the input side are tallied in a saturating counter and a sticky flag.
//
// Optional build macro: NARROW_SATURATE_EN
//   defined   -> overflowing inputs saturate to max positive / min negative
//   undefined -> overflowing inputs are plainly truncated
module narrow_check #(
    parameter int N_WIDE   = 32,
    parameter int N_NARROW = 17,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_WIDE-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_NARROW-1:0] out_data,
    output logic                out_ovf,
    output logic [N_WIDE-1:0]   out_sx,
    input  logic                clr_ovf,
    output logic                ovf_sticky,
    output logic [CNT_W-1:0]    ovf_count
);

    localparam int EXT_W = N_WIDE - N_NARROW;

    logic [N_WIDE-N_NARROW:0] top_bits;
    logic                     in_ovf;
    logic [N_NARROW-1:0]      in_narrow;

    logic [N_NARROW-1:0] data_q [2];
    logic                ovf_q  [2];
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [N_NARROW-1:0] out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]    ovf_count_q, ovf_count_d;
    logic                ovf_sticky_q, ovf_sticky_d;
    logic                push, pop;

    // Fit check and narrowing of the incoming value.
    always_comb begin
        top_bits  = in_data[N_WIDE-1:N_NARROW-1];
        in_ovf    = ~((&top_bits) | ~(|top_bits));
        in_narrow = in_data[N_NARROW-1:0];
`ifdef NARROW_SATURATE_EN
        if (in_ovf) begin
            in_narrow = in_data[N_WIDE-1] ? {1'b1, {(N_NARROW-1){1'b0}}}
                                          : {1'b0, {(N_NARROW-1){1'b1}}};
        end
`endif
    end

    // in_ready depends only on occupancy (and reset), so a pop never
    // frees a slot for a same-cycle push.
    assign in_ready  = ~reset & ~count_q[1];
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // FIFO pointer/occupancy next state and the next head entry.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        // Output registers track the next head; when empty they hold.
        if (count_d != 2'd0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = in_narrow;
                out_ovf_d  = in_ovf;
            end else begin
                out_data_d = data_q[rd_ptr_d];
                out_ovf_d  = ovf_q[rd_ptr_d];
            end
        end
    end

    // Overflow accounting on acceptance; clear and count combine when coincident.
    always_comb begin
        ovf_count_d  = ovf_count_q;
        ovf_sticky_d = ovf_sticky_q;
        if (clr_ovf) begin
            ovf_count_d  = '0;
            ovf_sticky_d = 1'b0;
        end
        if (push && in_ovf) begin
            ovf_sticky_d = 1'b1;
            if (ovf_count_d != {CNT_W{1'b1}}) ovf_count_d = ovf_count_d + 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q[0]    <= '0;
            data_q[1]    <= '0;
            ovf_q[0]     <= 1'b0;
            ovf_q[1]     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            ovf_count_q  <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            if (push) begin
                data_q[wr_ptr_q] <= in_narrow;
                ovf_q[wr_ptr_q]  <= in_ovf;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            ovf_count_q  <= ovf_count_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ovf    = out_ovf_q;
    assign out_sx     = {{EXT_W{out_data_q[N_NARROW-1]}}, out_data_q};
    assign ovf_count  = ovf_count_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_narrow_check.sv
// Directed bench for narrow_check with default parameters.
module tb_narrow_check;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;
    logic        out_ovf;
    logic [31:0] out_sx;
    logic        clr_ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;

    int checks = 0;
    int errors = 0;

    narrow_check dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .out_sx     (out_sx),
        .clr_ovf    (clr_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_hi got %0b exp 0", in_ready); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 17'h0 || out_sx !== 32'h0 || out_ovf !== 1'b0)
            begin errors++; $display("FAIL rst_out got %h/%h/%0b exp 0/0/0", out_data, out_sx, out_ovf); end
        checks++; if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0)
            begin errors++; $display("FAIL rst_ovf got %0d/%0b exp 0/0", ovf_count, ovf_sticky); end
    endtask

    task automatic test_fit_bounds();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000FFFF;
        step();
        in_valid = 1'b1; in_data = 32'hFFFF0000;
        checks++; if (out_valid !== 1'b1 || out_data !== 17'h0FFFF || out_ovf !== 1'b0 || out_sx !== 32'h0000FFFF)
            begin errors++; $display("FAIL max_pos got v%0b %h o%0b %h exp v1 0ffff o0 0000ffff", out_valid, out_data, out_ovf, out_sx); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 17'h10000 || out_ovf !== 1'b0 || out_sx !== 32'hFFFF0000)
            begin errors++; $display("FAIL min_neg got v%0b %h o%0b %h exp v1 10000 o0 ffff0000", out_valid, out_data, out_ovf, out_sx); end
        checks++; if (ovf_count !== 8'd0) begin errors++; $display("FAIL fit_no_count got %0d exp 0", ovf_count); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b exp 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [16:0] e1, e2;
        logic [31:0] s1, s2;
`ifdef NARROW_SATURATE_EN
        e1 = 17'h0FFFF; s1 = 32'h0000FFFF; e2 = 17'h10000; s2 = 32'hFFFF0000;
`else
        e1 = 17'h10000; s1 = 32'hFFFF0000; e2 = 17'h00000; s2 = 32'h00000000;
`endif
        in_valid = 1'b1; in_data = 32'h00010000;
        step();
        in_data = 32'h80000000;
        checks++; if (out_data !== e1 || out_ovf !== 1'b1 || out_sx !== s1)
            begin errors++; $display("FAIL ovf_first got %h o%0b %h exp %h o1 %h", out_data, out_ovf, out_sx, e1, s1); end
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== e2 || out_ovf !== 1'b1 || out_sx !== s2)
            begin errors++; $display("FAIL ovf_second got %h o%0b %h exp %h o1 %h", out_data, out_ovf, out_sx, e2, s2); end
        checks++; if (ovf_count !== 8'd2 || ovf_sticky !== 1'b1)
            begin errors++; $display("FAIL ovf_acct got %0d/%0b exp 2/1", ovf_count, ovf_sticky); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h00000011;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_one_ready got %0b exp 1", in_ready); end
        in_data = 32'h00000022;
        step();
        in_data = 32'h00000033;
        checks++; if (in_ready !== 1'b0 || out_data !== 17'h11) begin errors++; $display("FAIL bp_full got r%0b %h exp r0 11", in_ready, out_data); end
        step();
        checks++; if (in_ready !== 1'b0 || out_data !== 17'h11 || out_valid !== 1'b1)
            begin errors++; $display("FAIL bp_hold got r%0b %h v%0b exp r0 11 v1", in_ready, out_data, out_valid); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 17'h22 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_pop1 got %h r%0b exp 22 r1", out_data, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 17'h33 || out_valid !== 1'b1 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_pop2 got %h v%0b r%0b exp 33 v1 r1", out_data, out_valid, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 17'h33)
            begin errors++; $display("FAIL bp_empty_hold got v%0b %h exp v0 33", out_valid, out_data); end
    endtask

    task automatic test_counter_sat();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (ovf_count !== 8'd0 || ovf_sticky !== 1'b0)
            begin errors++; $display("FAIL clr_only got %0d/%0b exp 0/0", ovf_count, ovf_sticky); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h40000000;
        for (int i = 0; i < 255; i++) step();
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL cnt_255 got %0d exp 255", ovf_count); end
        step();
        checks++; if (ovf_count !== 8'd255) begin errors++; $display("FAIL cnt_sat got %0d exp 255", ovf_count); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1)
            begin errors++; $display("FAIL clr_push got %0d/%0b exp 1/1", ovf_count, ovf_sticky); end
        in_data = 32'h00000005;
        step();
        in_valid = 1'b0;
        checks++; if (ovf_count !== 8'd1 || out_data !== 17'h5 || out_ovf !== 1'b0)
            begin errors++; $display("FAIL fit_after got %0d %h o%0b exp 1 5 o0", ovf_count, out_data, out_ovf); end
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h7FFFFFFF;
        step();
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_full got v%0b r%0b exp v1 r0", out_valid, in_ready); end
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || ovf_count !== 8'd0 || out_data !== 17'h0 || in_ready !== 1'b0)
            begin errors++; $display("FAIL mid_reset got v%0b c%0d %h r%0b exp v0 c0 0 r0", out_valid, ovf_count, out_data, in_ready); end
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL mid_release got r%0b v%0b exp r1 v0", in_ready, out_valid); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hFFFFFFFF;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 17'h1FFFF || out_ovf !== 1'b0 || out_sx !== 32'hFFFFFFFF)
            begin errors++; $display("FAIL mid_first got v%0b %h o%0b %h exp v1 1ffff o0 ffffffff", out_valid, out_data, out_ovf, out_sx); end
        step();
    endtask

    initial begin
        test_reset();
        test_fit_bounds();
        test_overflow();
        test_backpressure();
        test_counter_sat();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
